// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro sequencer and its benches.
package cim_pkg;

  // Command length width and readback depth.
  localparam int CIM_LEN_W       = 8;
  localparam int CIM_NUM_OUT     = 8;

  // Address increment per beat: a LOAD beat writes 4 weight bytes, an MVM
  // beat covers 8 rows (one 4-bit activation per row).
  localparam int CIM_LOAD_STRIDE = 4;
  localparam int CIM_MVM_STRIDE  = 8;

  // Macro ADC resolution, used by reference models.
  localparam int ADC_PRECISION   = 6;

  // Command opcodes.
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_MVM  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    ACC,
    RD,
    OUT
  } state_t;

endpackage

// File: rtl/cim_sequencer.sv
// Initiator-side sequencer: turns LOAD/MVM commands plus a data stream into
// cycle-accurate macro pin activity and returns MVM column results.
module cim_sequencer
  import cim_pkg::*;
#(
  parameter int LEN_W       = CIM_LEN_W,
  parameter int NUM_OUT     = CIM_NUM_OUT,
  parameter int LOAD_STRIDE = CIM_LOAD_STRIDE,
  parameter int MVM_STRIDE  = CIM_MVM_STRIDE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [31:0]      cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [2:0]       res_idx,
  output logic             busy,
  output logic             done,
  output logic             cim_cs,
  output logic             cim_write,
  output logic             cim_en,
  output logic             cim_partial_sum,
  output logic             cim_reset_output,
  output logic [3:0]       cim_output_reg,
  output logic [31:0]      cim_address,
  output logic [31:0]      cim_input_data,
  output logic             cim_debug,
  input  logic [31:0]      cim_output
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      base_q, base_d;
  logic [2:0]       i_q, i_d;
  logic             done_pend_q, done_pend_d;
  logic             done_q, done_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [2:0]       res_idx_q, res_idx_d;
  logic             cs_q, cs_d;
  logic             write_q, write_d;
  logic             en_q, en_d;
  logic             ps_q, ps_d;
  logic             ro_q, ro_d;
  logic [3:0]       oreg_q, oreg_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  // ACC keeps one extra cycle after the final accept (k == len) so the last
  // accumulate issue completes before the first readback cycle.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == LOAD) || ((state_q == ACC) && (k_q != len_q));
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;

  assign cim_cs           = cs_q;
  assign cim_write        = write_q;
  assign cim_en           = en_q;
  assign cim_partial_sum  = ps_q;
  assign cim_reset_output = ro_q;
  assign cim_output_reg   = oreg_q;
  assign cim_address      = addr_q;
  assign cim_input_data   = wdata_q;
  assign cim_debug        = 1'b0;

  // Next-state and next-pin computation; the *_d pin values show up on the
  // macro one cycle later.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    len_d       = len_q;
    base_d      = base_q;
    i_d         = i_q;
    done_pend_d = 1'b0;
    done_d      = done_pend_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    cs_d        = 1'b0;
    write_d     = 1'b0;
    en_d        = 1'b0;
    ps_d        = 1'b0;
    ro_d        = 1'b0;
    oreg_d      = oreg_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d = cmd_base;
          len_d  = cmd_len;
          k_d    = '0;
          if (cmd_op == OP_MVM) begin
            // The clear issue lands in the CLR cycle itself.
            state_d = CLR;
            cs_d    = 1'b1;
            en_d    = 1'b1;
            ro_d    = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (in_valid) begin
          cs_d    = 1'b1;
          write_d = 1'b1;
          addr_d  = base_q + 32'(k_q) * 32'(LOAD_STRIDE);
          wdata_d = in_data;
          k_d     = k_q + LEN_W'(1);
          if (k_q == len_q - LEN_W'(1)) begin
            // Done follows the cycle in which the last write is on the pins.
            state_d     = IDLE;
            done_pend_d = 1'b1;
          end
        end
      end

      CLR: begin
        en_d = 1'b1;
        if (len_q == '0) begin
          state_d = RD;
          i_d     = 3'd0;
          oreg_d  = 4'd0;
        end else begin
          state_d = ACC;
        end
      end

      ACC: begin
        en_d = 1'b1;
        if (k_q == len_q) begin
          state_d = RD;
          i_d     = 3'd0;
          oreg_d  = 4'd0;
        end else if (in_valid) begin
          cs_d    = 1'b1;
          ps_d    = 1'b1;
          addr_d  = base_q + 32'(k_q) * 32'(MVM_STRIDE);
          wdata_d = in_data;
          k_d     = k_q + LEN_W'(1);
        end
      end

      RD: begin
        en_d        = 1'b1;
        res_data_d  = cim_output;
        res_idx_d   = i_q;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        en_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (i_q == 3'(NUM_OUT - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            en_d    = 1'b0;
          end else begin
            i_d     = i_q + 3'd1;
            oreg_d  = {1'b0, i_q + 3'd1};
            state_d = RD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered pins; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      len_q       <= '0;
      base_q      <= '0;
      i_q         <= '0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      cs_q        <= 1'b0;
      write_q     <= 1'b0;
      en_q        <= 1'b0;
      ps_q        <= 1'b0;
      ro_q        <= 1'b0;
      oreg_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      base_q      <= base_d;
      i_q         <= i_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      cs_q        <= cs_d;
      write_q     <= write_d;
      en_q        <= en_d;
      ps_q        <= ps_d;
      ro_q        <= ro_d;
      oreg_q      <= oreg_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cim_sequencer.sv
// Bench for cim_sequencer: behavioural macro, command-level reference model,
// directed scenarios followed by randomized LOAD/MVM traffic.
module tb_cim_sequencer;
  import cim_pkg::*;

  localparam int ADC_SHIFT = 15 - ADC_PRECISION;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_base;
  logic [7:0]  cmd_len;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_idx;
  logic        busy, done;
  logic        cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output;
  logic [3:0]  cim_output_reg;
  logic [31:0] cim_address, cim_input_data, cim_output;
  logic        cim_debug;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cim_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done),
    .cim_cs(cim_cs), .cim_write(cim_write), .cim_en(cim_en),
    .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
    .cim_output_reg(cim_output_reg), .cim_address(cim_address),
    .cim_input_data(cim_input_data), .cim_debug(cim_debug), .cim_output(cim_output)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // 6-bit ADC reading of a row-sum: bits [14:9], sign-extended.
  function automatic int adc_q(input int s);
    int t;
    t = (s >>> ADC_SHIFT) & ((1 << ADC_PRECISION) - 1);
    if (t >= (1 << (ADC_PRECISION - 1))) t -= (1 << ADC_PRECISION);
    return t;
  endfunction

  // ---------------- behavioural macro (128 rows x 8 signed byte columns) ----
  logic [7:0]         mac_mem [0:1023] = '{default: 8'h00};
  logic signed [31:0] mac_acc [0:7]    = '{default: 32'sd0};

  assign cim_output = mac_acc[cim_output_reg[2:0]];

  function automatic int mac_col(input logic [6:0] rb, input logic [31:0] act, input int c);
    int s = 0;
    for (int r = 0; r < 8; r++) begin
      byte w;
      w = mac_mem[((int'(rb) + r) % 128) * 8 + c];
      s += int'(act[31-4*r -: 4]) * int'(w);
    end
    return adc_q(s);
  endfunction

  always @(posedge clk) begin
    if (cim_cs && cim_write) begin
      for (int j = 0; j < 4; j++)
        mac_mem[cim_address[9:0] + 10'(j)] <= cim_input_data[31-8*j -: 8];
    end else if (cim_cs && cim_en && cim_reset_output) begin
      for (int c = 0; c < 8; c++) mac_acc[c] <= 32'sd0;
    end else if (cim_cs && cim_en && cim_partial_sum) begin
      for (int c = 0; c < 8; c++)
        mac_acc[c] <= mac_acc[c] + 32'(mac_col(cim_address[6:0], cim_input_data, c));
    end
  end

  // ---------------- pin monitor -------------------------------------------
  typedef struct {
    logic        wr;
    logic        ps;
    logic        ro;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } iss_t;

  iss_t issue_q[$];
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (cim_cs)
      issue_q.push_back('{cim_write, cim_partial_sum, cim_reset_output, cim_en,
                          cim_address, cim_input_data});
    if (done) done_cnt++;
  end

  // ---------------- command-level reference model -------------------------
  logic [7:0] ref_w [0:1023] = '{default: 8'h00};

  // Column c after an MVM: per beat k, rows (base + 8k)[6:0] + r (mod 128)
  // are weighted by activation nibble r, each beat quantised then summed.
  function automatic int ref_col(input logic [31:0] base, input logic [31:0] acts[$], input int c);
    int tot = 0;
    foreach (acts[k]) begin
      logic [31:0] a;
      int s;
      a = base + 32'(CIM_MVM_STRIDE) * 32'(k);
      s = 0;
      for (int r = 0; r < 8; r++) begin
        byte w;
        w = ref_w[((int'(a[6:0]) + r) % 128) * 8 + c];
        s += int'(acts[k][31-4*r -: 4]) * int'(w);
      end
      tot += adc_q(s);
    end
    return tot;
  endfunction

  // ---------------- drivers (called at a negedge) -------------------------
  task automatic send_cmd(input string tag, input logic op, input logic [31:0] base,
                          input logic [7:0] len);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input string tag, input logic [31:0] data, input int gap);
    int t = 0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_eq({tag, "_gap_cs"}, cim_cs, 0);
      check_eq({tag, "_gap_cmd_ready"}, cmd_ready, 0);
    end
    in_valid = 1'b1; in_data = data;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check_eq({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] base, input logic [31:0] words[$],
                         input int max_gap);
    int n  = words.size();
    int ib = issue_q.size();
    int db = done_cnt;
    send_cmd(tag, OP_LOAD, base, 8'(n));
    if (n == 0) begin
      check_eq({tag, "_done_len0"}, done, 1);
      check_eq({tag, "_busy_len0"}, busy, 0);
    end else begin
      check_eq({tag, "_busy"}, busy, 1);
      for (int k = 0; k < n; k++) begin
        send_beat(tag, words[k], (k == 0) ? 0 : int'($urandom_range(0, max_gap)));
        for (int j = 0; j < 4; j++)
          ref_w[10'(base + 32'(4 * k + j))] = words[k][31-8*j -: 8];
      end
      check_eq({tag, "_last_cs_done"}, {cim_cs, done}, 2'b10);
      @(negedge clk);
      check_eq({tag, "_done"}, done, 1);
    end
    @(negedge clk);
    check_eq({tag, "_done_count"}, done_cnt - db, 1);
    check_eq({tag, "_issue_count"}, issue_q.size() - ib, n);
    for (int k = 0; k < n && ib + k < issue_q.size(); k++) begin
      check_eq({tag, "_wr_en"}, {issue_q[ib+k].wr, issue_q[ib+k].en}, 2'b10);
      check_eq({tag, "_addr"}, issue_q[ib+k].addr, base + 32'(4 * k));
      check_eq({tag, "_data"}, issue_q[ib+k].data, words[k]);
    end
    $display("TXN LOAD %s base=0x%08h len=%0d", tag, base, n);
  endtask

  task automatic collect(input string tag, input int exp_v[8], input int stall_idx,
                         input int stall_len);
    int          got = 0, t = 0, stalls = 0, bad_rb = 0;
    bit          seen = 0, pend = 0;
    logic [31:0] pd;
    logic [2:0]  pi;
    while (got < 8 && t < 3000) begin
      t++;
      res_ready = 1'b0;
      if (res_valid) seen = 1;
      if (seen && (cim_cs !== 1'b0 || cim_en !== 1'b1)) bad_rb++;
      if (res_valid) begin
        if (pend) begin
          check_eq({tag, "_hold_data"}, res_data, pd);
          check_eq({tag, "_hold_idx"}, res_idx, pi);
        end
        if ((int'(res_idx) == stall_idx && stalls < stall_len) || $urandom_range(0, 3) == 0) begin
          if (int'(res_idx) == stall_idx) stalls++;
          pend = 1; pd = res_data; pi = res_idx;
        end else begin
          res_ready = 1'b1;
          pend = 0;
          check_eq({tag, "_res_idx"}, res_idx, got);
          check_eq({tag, "_res_data"}, res_data, 32'(exp_v[got]));
          got++;
        end
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    check_eq({tag, "_results_seen"}, got, 8);
    check_eq({tag, "_readback_cs0_en1"}, bad_rb, 0);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_idle"}, {busy, cmd_ready}, 2'b01);
  endtask

  task automatic do_mvm(input string tag, input logic [31:0] base, input logic [31:0] acts[$],
                        input int gap, input int stall_idx, input int stall_len);
    int exp_v[8];
    int n  = acts.size();
    int ib = issue_q.size();
    int db = done_cnt;
    for (int c = 0; c < 8; c++) exp_v[c] = ref_col(base, acts, c);
    send_cmd(tag, OP_MVM, base, 8'(n));
    check_eq({tag, "_busy"}, busy, 1);
    for (int k = 0; k < n; k++)
      send_beat(tag, acts[k], (k == 0) ? 0 : ((gap >= 0) ? gap : int'($urandom_range(0, 2))));
    collect(tag, exp_v, stall_idx, stall_len);
    @(negedge clk);
    check_eq({tag, "_done_count"}, done_cnt - db, 1);
    check_eq({tag, "_issue_count"}, issue_q.size() - ib, n + 1);
    if (issue_q.size() >= ib + n + 1) begin
      check_eq({tag, "_clr_pins"},
               {issue_q[ib].wr, issue_q[ib].ps, issue_q[ib].ro, issue_q[ib].en}, 4'b0011);
      for (int k = 0; k < n; k++) begin
        iss_t e;
        e = issue_q[ib+1+k];
        check_eq({tag, "_acc_pins"}, {e.wr, e.ps, e.ro, e.en}, 4'b0101);
        check_eq({tag, "_acc_addr"}, e.addr, base + 32'(CIM_MVM_STRIDE * k));
        check_eq({tag, "_acc_data"}, e.data, acts[k]);
      end
    end
    $display("TXN MVM %s base=0x%08h len=%0d col0=%0d col7=%0d", tag, base, n, exp_v[0], exp_v[7]);
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    logic [31:0] words[$];
    logic [31:0] acts[$];
    cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0;
    in_valid = 0; in_data = 0; res_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output, cim_debug}, 0);
    check_eq("rst_addr", cim_address, 0);
    check_eq("rst_wdata", cim_input_data, 0);
    check_eq("rst_oreg", cim_output_reg, 0);
    check_eq("rst_res", {res_valid, res_idx, done, busy, in_ready}, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed LOAD of four known words.
    words = {};
    words.push_back(32'h01020304); words.push_back(32'h05060708);
    words.push_back(32'h090A0B0C); words.push_back(32'h0D0E0F10);
    do_load("load4", 32'h0, words, 0);
    check_eq("load4_mem5", mac_mem[5], 8'h06);

    // Zero-length LOAD: done only, no issue.
    words = {};
    do_load("load0", 32'h100, words, 0);

    // Uniform weights 0x40 across all 1024 bytes.
    words = {};
    for (int k = 0; k < 128; k++) words.push_back(32'h40404040);
    do_load("w40_lo", 32'h0, words, 1);
    do_load("w40_hi", 32'h200, words, 1);

    acts = {}; acts.push_back(32'hFFFFFFFF);
    do_mvm("mvm1", 32'h0, acts, 0, -1, 0);
    acts.push_back(32'hFFFFFFFF);
    do_mvm("mvm2", 32'h0, acts, 0, -1, 0);
    acts = {}; acts.push_back(32'hFFFFFFFF);
    do_mvm("mvm_stall", 32'h0, acts, 0, 3, 5);
    acts.push_back(32'hFFFFFFFF);
    do_mvm("mvm_gap", 32'h0, acts, 3, -1, 0);

    // Reset in the middle of accumulation, with a beat in flight.
    send_cmd("rst_mid", OP_MVM, 32'h0, 8'd4);
    send_beat("rst_mid", 32'hFFFFFFFF, 0);
    send_beat("rst_mid", 32'hFFFFFFFF, 0);
    check_eq("rst_mid_pre_cs", cim_cs, 1);
    in_valid = 1'b1; in_data = 32'hFFFFFFFF;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctrl", {cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output}, 0);
    check_eq("rst_mid_addr", cim_address, 0);
    check_eq("rst_mid_state", {res_valid, busy, in_ready, cmd_ready}, 4'b0001);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acts = {}; acts.push_back(32'hFFFFFFFF);
    do_mvm("post_rst", 32'h0, acts, 0, -1, 0);

    // Randomized weights and commands.
    for (int h = 0; h < 2; h++) begin
      words = {};
      for (int k = 0; k < 128; k++) words.push_back($urandom);
      do_load("rnd_w", 32'(h * 512), words, 1);
    end
    for (int m = 0; m < 10; m++) begin
      if (m == 5) begin
        words = {};
        for (int k = 0; k < int'($urandom_range(1, 8)); k++) words.push_back($urandom);
        do_load("rnd_patch", $urandom, words, 2);
      end
      acts = {};
      for (int k = 0; k < int'($urandom_range(0, 20)); k++) acts.push_back($urandom);
      do_mvm("rnd_mvm", $urandom, acts, -1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
